display_scan_arbiter: RTL

//  Scan controller and two-source arbiter for the 4-digit multiplexed hex display.

---
 rtl/display_scan_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_arbiter.sv
// Multiplexed hex display scanner with a frame-synchronous two-source arbiter.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module display_scan_arbiter #(
    parameter int DIGITS      = 4,
    parameter int DWELL       = 1,
    parameter int HOLD_FRAMES = 50
) (
    input  logic        clk_200Hz,
    input  logic        rst,
    input  logic        EN,
    input  logic [15:0] a_data,
    input  logic [3:0]  a_dot,
    input  logic        b_req,
    input  logic [15:0] b_data,
    input  logic [3:0]  b_dot,
    output logic        b_gnt,
    output logic        b_done,
    output logic [3:0]  sm_duan,
    output logic        sm_dot,
    output logic [7:0]  sm_wei
);

    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int HW  = $clog2(HOLD_FRAMES + 1);

    localparam logic [2:0]     LAST_IDX   = 3'(DIGITS - 1);
    localparam logic [DWW-1:0] LAST_DWELL = DWW'(DWELL - 1);
    localparam logic [HW-1:0]  HOLD_MAX   = HW'(HOLD_FRAMES);

    // Nibbles and dots beyond the configured digit count are forced to zero
    function automatic logic [31:0] data_mask();
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int k = 0; k < 8; k++) begin
            if (k < DIGITS) m[4*k +: 4] = 4'hF;
            else            m[4*k +: 4] = 4'h0;
        end
        return m;
    endfunction

    function automatic logic [7:0] dot_mask();
        logic [7:0] m;
        m = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (k < DIGITS) m[k] = 1'b1;
            else            m[k] = 1'b0;
        end
        return m;
    endfunction

    localparam logic [31:0] DATA_MASK = data_mask();
    localparam logic [7:0]  DOT_MASK  = dot_mask();

    typedef enum logic [1:0] {
        SHOW_A = 2'd0,
        PEND_B = 2'd1,
        SHOW_B = 2'd2
    } arb_state_t;

    arb_state_t      state_r, state_next_s;
    logic [2:0]      idx_r;
    logic [DWW-1:0]  dwell_r;
    logic [HW-1:0]   hold_r, hold_next_s, hold_inc_s;
    logic            take_b_s;
    logic            fs_s;
    logic [31:0]     snap_data_r, sel_data_s, a_ext_s, b_ext_s;
    logic [7:0]      snap_dot_r, sel_dot_s, a_dot_ext_s, b_dot_ext_s;
    logic [3:0]      nibble_s;
    logic            dot_s;
    logic            blank_s;
    logic [7:0]      wei_s;
    logic [7:0]      sm_wei_r;
    logic [3:0]      sm_duan_r;
    logic            sm_dot_r;
    logic            b_gnt_r;
    logic            b_done_r;

    assign a_ext_s     = {16'h0000, a_data} & DATA_MASK;
    assign b_ext_s     = {16'h0000, b_data} & DATA_MASK;
    assign a_dot_ext_s = {4'h0, a_dot} & DOT_MASK;
    assign b_dot_ext_s = {4'h0, b_dot} & DOT_MASK;

    // A frame only starts while the display is enabled
    assign fs_s       = EN && (idx_r == 3'd0) && (dwell_r == {DWW{1'b0}});
    assign hold_inc_s = (hold_r >= HOLD_MAX) ? HOLD_MAX : (hold_r + HW'(1));

    // Digit scan counters; held at digit 0 while blanked so re-enable starts a frame
    always_ff @(posedge clk_200Hz) begin
        if (rst) begin
            idx_r   <= 3'd0;
            dwell_r <= {DWW{1'b0}};
        end else if (!EN) begin
            idx_r   <= 3'd0;
            dwell_r <= {DWW{1'b0}};
        end else if (dwell_r == LAST_DWELL) begin
            dwell_r <= {DWW{1'b0}};
            idx_r   <= (idx_r == LAST_IDX) ? 3'd0 : (idx_r + 3'd1);
        end else begin
            dwell_r <= dwell_r + DWW'(1);
        end
    end

    // Arbitration next-state; ownership only changes hands at frame starts
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_r;
        take_b_s     = 1'b0;
        case (state_r)
            SHOW_A: begin
                if (EN && b_req) state_next_s = PEND_B;
                else             state_next_s = SHOW_A;
            end
            PEND_B: begin
                if (fs_s && b_req) begin
                    state_next_s = SHOW_B;
                    hold_next_s  = {HW{1'b0}};
                    take_b_s     = 1'b1;
                end else if (fs_s) begin
                    state_next_s = SHOW_A;
                end else begin
                    state_next_s = PEND_B;
                end
            end
            SHOW_B: begin
                if (fs_s) begin
                    hold_next_s = hold_inc_s;
                    if ((hold_inc_s >= HOLD_MAX) && !b_req) begin
                        state_next_s = SHOW_A;
                    end else begin
                        state_next_s = SHOW_B;
                        take_b_s     = 1'b1;
                    end
                end else begin
                    state_next_s = SHOW_B;
                end
            end
            default: begin
                state_next_s = SHOW_A;
            end
        endcase
    end

    // Arbitration state and hold counter registers
    always_ff @(posedge clk_200Hz) begin
        if (rst) begin
            state_r <= SHOW_A;
            hold_r  <= {HW{1'b0}};
        end else begin
            state_r <= state_next_s;
            hold_r  <= hold_next_s;
        end
    end

    // At a frame start the new owner's data is used immediately for digit 0
    always_comb begin
        sel_data_s = snap_data_r;
        sel_dot_s  = snap_dot_r;
        if (fs_s && take_b_s) begin
            sel_data_s = b_ext_s;
            sel_dot_s  = b_dot_ext_s;
        end else if (fs_s) begin
            sel_data_s = a_ext_s;
            sel_dot_s  = a_dot_ext_s;
        end else begin
            sel_data_s = snap_data_r;
            sel_dot_s  = snap_dot_r;
        end
    end

    // Frame snapshot register, reloaded only at frame starts
    always_ff @(posedge clk_200Hz) begin
        if (rst) begin
            snap_data_r <= 32'h0000_0000;
            snap_dot_r  <= 8'h00;
        end else if (fs_s) begin
            snap_data_r <= sel_data_s;
            snap_dot_r  <= sel_dot_s;
        end else begin
            snap_data_r <= snap_data_r;
            snap_dot_r  <= snap_dot_r;
        end
    end

    // Active digit decode, including optional leading-zero blanking
    always_comb begin
        nibble_s = sel_data_s[{idx_r, 2'b00} +: 4];
        dot_s    = sel_dot_s[idx_r];
`ifdef DISP_LZB_EN
        if ((idx_r != 3'd0) &&
            ((sel_data_s >> {idx_r, 2'b00}) == 32'h0000_0000) &&
            ((sel_dot_s >> idx_r) == 8'h00)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
`else
        blank_s = 1'b0;
`endif
        if (blank_s) wei_s = 8'hFF;
        else         wei_s = ~(8'h01 << idx_r);
    end

    // Registered display and handshake outputs
    always_ff @(posedge clk_200Hz) begin
        if (rst) begin
            sm_wei_r  <= 8'hFF;
            sm_duan_r <= 4'h0;
            sm_dot_r  <= 1'b0;
            b_gnt_r   <= 1'b0;
            b_done_r  <= 1'b0;
        end else begin
            if (!EN) begin
                sm_wei_r  <= 8'hFF;
                sm_duan_r <= 4'h0;
                sm_dot_r  <= 1'b0;
            end else begin
                sm_wei_r  <= wei_s;
                sm_duan_r <= nibble_s;
                sm_dot_r  <= dot_s;
            end
            b_gnt_r  <= (state_next_s == SHOW_B);
            b_done_r <= (state_r == SHOW_B) && (state_next_s == SHOW_A);
        end
    end

    assign sm_wei  = sm_wei_r;
    assign sm_duan = sm_duan_r;
    assign sm_dot  = sm_dot_r;
    assign b_gnt   = b_gnt_r;
    assign b_done  = b_done_r;

endmodule
